// File: rtl/mod_counter_pkg.sv
// Shared types for mod_counter: counting modes and one-shot FSM states.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    MODULO  = 2'b01,
    ONESHOT = 2'b10,
    HOLD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } os_state_t;

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler for mod_counter: pulses tick on every PRESCALE-th en cycle.
module mod_counter_prescaler #(
  parameter int unsigned WIDTH_P  = 2,
  parameter int unsigned PRESCALE = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic sync_rst,
  output logic tick
);

  localparam logic [WIDTH_P-1:0] Last = WIDTH_P'(PRESCALE - 1);

  logic [WIDTH_P-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (sync_rst) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == Last) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down counter with free-run, modulo and one-shot modes.
// Optional enable prescaler is compiled in with MOD_COUNTER_PRESCALE_EN.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || PRESCALE < 1) begin : g_param_check
    $error("mod_counter: WIDTH must be >= 2 and PRESCALE >= 1");
  end

  mode_t            mode_e;
  os_state_t        state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             step;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] target;

  assign mode_e = mode_t'(mode);

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int unsigned TickW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  mod_counter_prescaler #(
    .WIDTH_P (TickW),
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .en      (en),
    .sync_rst(clr | load | start),
    .tick    (step)
  );
`else
  assign step = en;
`endif

  assign nxt    = dir ? out_q + 1'b1 : out_q - 1'b1;
  assign target = dir ? limit : '0;

  always_comb begin
    out_d   = out_q;
    tc_d    = 1'b0;
    state_d = state_q;
    // Leaving one-shot mode drops the FSM back to IDLE but keeps the count.
    if (mode_e != ONESHOT) state_d = IDLE;

    if (clr) begin
      out_d   = '0;
      state_d = IDLE;
    end else if (load) begin
      out_d = load_val;
    end else if (start && mode_e == ONESHOT) begin
      state_d = RUN;
      out_d   = dir ? '0 : limit;
    end else if (step) begin
      unique case (mode_e)
        FREE: begin
          out_d = nxt;
          tc_d  = dir ? (out_q == '1) : (out_q == '0);
        end
        MODULO: begin
          if (dir) begin
            if (out_q >= limit) begin
              out_d = '0;
              tc_d  = 1'b1;
            end else begin
              out_d = nxt;
            end
          end else if (out_q == '0 || out_q > limit) begin
            out_d = limit;
            tc_d  = 1'b1;
          end else begin
            out_d = nxt;
          end
        end
        ONESHOT: begin
          if (state_q == RUN) begin
            // A run already sitting on its target finishes without moving.
            if (out_q == target) begin
              tc_d    = 1'b1;
              state_d = DONE;
            end else begin
              out_d = nxt;
              if (nxt == target) begin
                tc_d    = 1'b1;
                state_d = DONE;
              end
            end
          end
        end
        HOLD: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q   <= '0;
      tc_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      out_q   <= out_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mod_counter.sv
// Randomised self-checking bench for mod_counter against an arithmetic reference model.
module tb_mod_counter;

  localparam int W = 8;
  localparam int P = 4;
  localparam int M = 256;
`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int SC = P;
`else
  localparam int SC = 1;
`endif

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         en = 1'b0, clr = 1'b0, load = 1'b0, start = 1'b0, dir = 1'b1;
  logic [W-1:0] load_val = '0, limit = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] out;
  logic         tc, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: count value, tc pulse, one-shot phase (0 idle, 1 run, 2 done), tick.
  int m_out = 0;
  int m_st  = 0;
  int m_pre = 0;
  bit m_tc  = 1'b0;

  always #5 CLK = ~CLK;

  mod_counter #(
    .WIDTH   (W),
    .PRESCALE(P)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .en      (en),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .dir     (dir),
    .mode    (mode),
    .limit   (limit),
    .start   (start),
    .out     (out),
    .tc      (tc),
    .busy    (busy),
    .done    (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap_add(input int v, input int d);
    return (v + d + M) % M;
  endfunction

  function automatic void model_edge();
    bit step;
    int lim, tgt;
    lim  = int'(limit);
    m_tc = 1'b0;
    if (mode != 2'b10) m_st = 0;
    step = en;
`ifdef MOD_COUNTER_PRESCALE_EN
    step = 1'b0;
    if (clr || load || start) m_pre = 0;
    else if (en) begin
      if (m_pre == P - 1) begin
        step  = 1'b1;
        m_pre = 0;
      end else m_pre++;
    end
`endif
    if (clr) begin
      m_out = 0;
      m_st  = 0;
    end else if (load) begin
      m_out = int'(load_val);
    end else if (start && mode == 2'b10) begin
      m_st  = 1;
      m_out = dir ? 0 : lim;
    end else if (step) begin
      case (mode)
        2'b00: begin
          m_tc  = dir ? (m_out == M - 1) : (m_out == 0);
          m_out = wrap_add(m_out, dir ? 1 : -1);
        end
        2'b01: begin
          if (dir) begin
            if (m_out >= lim) begin m_out = 0; m_tc = 1'b1; end
            else m_out = m_out + 1;
          end else begin
            if (m_out == 0 || m_out > lim) begin m_out = lim; m_tc = 1'b1; end
            else m_out = m_out - 1;
          end
        end
        2'b10: begin
          if (m_st == 1) begin
            tgt = dir ? lim : 0;
            if (m_out != tgt) m_out = wrap_add(m_out, dir ? 1 : -1);
            if (m_out == tgt) begin
              m_tc = 1'b1;
              m_st = 2;
            end
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic cyc(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_eq({tag, "_out"}, 32'(out), m_out);
    check_eq({tag, "_tc"}, 32'(tc), 32'(m_tc));
    check_eq({tag, "_busy"}, 32'(busy), 32'(m_st == 1));
    check_eq({tag, "_done"}, 32'(done), 32'(m_st == 2));
  endtask

  // One logical count step: SC enabled cycles.
  task automatic adv(input string tag);
    repeat (SC) cyc(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2 RST_N = 1'b0;
    #1;
    check_eq({tag, "_out"}, 32'(out), 0);
    check_eq({tag, "_tc"}, 32'(tc), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    m_out = 0; m_st = 0; m_pre = 0; m_tc = 1'b0;
    #1 RST_N = 1'b1;
  endtask

  initial begin
    #12;
    check_eq("rst_out", 32'(out), 0);
    check_eq("rst_tc", 32'(tc), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    RST_N = 1'b1;

    // Free-run wrap up and down.
    mode = 2'b00; dir = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'hFE;
    cyc("fr_ld");
    check_eq("fr_fe", 32'(out), 32'hFE);
    load = 1'b0;
    adv("fr_up"); check_eq("fr_ff", 32'(out), 32'hFF); check_eq("fr_ff_tc", 32'(tc), 0);
    adv("fr_up"); check_eq("fr_00", 32'(out), 32'h00); check_eq("fr_00_tc", 32'(tc), 1);
    load = 1'b1; load_val = 8'h01; dir = 1'b0;
    cyc("fr_ld2");
    load = 1'b0;
    adv("fr_dn"); check_eq("fr_dn_00", 32'(out), 0); check_eq("fr_dn_00_tc", 32'(tc), 0);
    adv("fr_dn"); check_eq("fr_dn_ff", 32'(out), 32'hFF); check_eq("fr_dn_ff_tc", 32'(tc), 1);

    // Modulo-6 up, out-of-range load, down from 0.
    mode = 2'b01; dir = 1'b1; limit = 8'd5; load = 1'b1; load_val = 8'd0;
    cyc("mod_ld");
    load = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      adv("mod_up");
      check_eq("mod_seq", 32'(out), i % 6);
      check_eq("mod_seq_tc", 32'(tc), 32'(i % 6 == 0));
    end
    load = 1'b1; load_val = 8'd9;
    cyc("mod_ld9");
    load = 1'b0;
    adv("mod_over"); check_eq("mod_over_out", 32'(out), 0); check_eq("mod_over_tc", 32'(tc), 1);
    dir = 1'b0;
    adv("mod_dn"); check_eq("mod_dn_out", 32'(out), 5); check_eq("mod_dn_tc", 32'(tc), 1);

    // One-shot up to 3, then restart.
    mode = 2'b10; dir = 1'b1; limit = 8'd3; start = 1'b1;
    cyc("os_start");
    check_eq("os_busy", 32'(busy), 1);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      adv("os_run");
      check_eq("os_seq", 32'(out), i);
    end
    check_eq("os_done", 32'(done), 1);
    check_eq("os_done_tc", 32'(tc), 1);
    adv("os_hold"); check_eq("os_hold_out", 32'(out), 3); check_eq("os_hold_tc", 32'(tc), 0);
    start = 1'b1;
    cyc("os_restart");
    check_eq("os_re_out", 32'(out), 0); check_eq("os_re_busy", 32'(busy), 1);
    start = 1'b0;

    // Priority: clr beats load and start; load beats step.
    clr = 1'b1; load = 1'b1; start = 1'b1; load_val = 8'hAA;
    cyc("pri_all");
    check_eq("pri_out", 32'(out), 0); check_eq("pri_busy", 32'(busy), 0);
    clr = 1'b0; start = 1'b0; mode = 2'b00; dir = 1'b1;
    cyc("pri_ld");
    check_eq("pri_ld_out", 32'(out), 32'hAA);
    load = 1'b0;

    // Twelve enabled cycles from zero.
    clr = 1'b1;
    cyc("ps_clr");
    clr = 1'b0;
    repeat (12) cyc("ps_run");
    check_eq("ps_out", 32'(out), 12 / SC);

    // Reset mid-count at 0x37.
    load = 1'b1; load_val = 8'h37;
    cyc("rst_ld");
    load = 1'b0;
    cyc("rst_run");
    do_reset("rst_mid");

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 6) mode = 2'($urandom_range(3));
      en    = ($urandom_range(99) < 80);
      clr   = ($urandom_range(99) < 3);
      load  = ($urandom_range(99) < 5);
      start = ($urandom_range(99) < 8);
      if ($urandom_range(99) < 10) dir = ~dir;
      if ($urandom_range(99) < 5)
        limit = ($urandom_range(1) == 1) ? 8'($urandom_range(12)) : 8'($urandom);
      load_val = 8'($urandom);
      if ($urandom_range(299) == 0) do_reset("rnd_rst");
      else cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
